// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the BIU master port and the memory bus switch.
// Optional macro WBUF_RAW_FORWARD_EN enables read forwarding from full-word FIFO entries.
module mem_write_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    input  logic [3:0]  s_sel_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        empty_o
);

    localparam int N  = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]           r_fifo_adr [N];
    logic [31:0]           r_fifo_dat [N];
    logic [3:0]            r_fifo_sel [N];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CW-1:0]         r_count;

    logic        r_rd_pend;
    logic [31:0] r_rd_adr;
    logic [3:0]  r_rd_sel;
    logic [31:0] r_m_adr;
    logic [31:0] r_m_dat;
    logic [3:0]  r_m_sel;
    logic        r_s_ack;
    logic [31:0] r_s_dat;
    logic        r_empty;

    logic        w_new_req;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_rd_done;
    logic        w_rd_req;
    logic        w_fwd_hit;
    logic [31:0] w_fwd_dat;

    // The cycle carrying s_ack_o still shows the acknowledged strobe.
    assign w_new_req = s_stb_i & ~r_s_ack & ~r_rd_pend;
    assign w_full    = (r_count == FULL);
    assign w_push    = w_new_req & s_we_i & ~w_full;
    assign w_pop     = (r_state == S_WR) & m_ack_i;
    assign w_rd_done = (r_state == S_RD) & m_ack_i;
    assign w_rd_req  = w_new_req & ~s_we_i & ~w_fwd_hit;

`ifdef WBUF_RAW_FORWARD_EN
    logic        w_fwd_match;
    logic [3:0]  w_fwd_sel;

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        w_fwd_match = 1'b0;
        w_fwd_dat   = '0;
        w_fwd_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if ((CW'(i) < r_count) &&
                (r_fifo_adr[r_rptr + DEPTH_LOG2'(i)][31:2] == s_adr_i[31:2])) begin
                w_fwd_match = 1'b1;
                w_fwd_dat   = r_fifo_dat[r_rptr + DEPTH_LOG2'(i)];
                w_fwd_sel   = r_fifo_sel[r_rptr + DEPTH_LOG2'(i)];
            end
        end
    end

    assign w_fwd_hit = w_new_req & ~s_we_i & w_fwd_match & (w_fwd_sel == 4'hF);
`else
    assign w_fwd_hit = 1'b0;
    assign w_fwd_dat = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_WR;
                end else if (r_rd_pend) begin
                    w_state_nxt = S_RD;
                end
            end
            S_WR: begin
                if (m_ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                if (m_ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_stb_o = (r_state != S_IDLE);
        m_we_o  = (r_state == S_WR);
    end

    assign m_adr_o = r_m_adr;
    assign m_dat_o = r_m_dat;
    assign m_sel_o = r_m_sel;
    assign s_ack_o = r_s_ack;
    assign s_dat_o = r_s_dat;
    assign empty_o = r_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_adr[r_wptr] <= s_adr_i;
            r_fifo_dat[r_wptr] <= s_dat_i;
            r_fifo_sel[r_wptr] <= s_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rd_pend <= 1'b0;
            r_rd_adr  <= '0;
            r_rd_sel  <= '0;
        end else if (w_rd_req) begin
            r_rd_pend <= 1'b1;
            r_rd_adr  <= s_adr_i;
            r_rd_sel  <= s_sel_i;
        end else if (w_rd_done) begin
            r_rd_pend <= 1'b0;
        end
    end

    // Bus fields load only when leaving IDLE, so they hold for the whole strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_m_adr <= '0;
            r_m_dat <= '0;
            r_m_sel <= '0;
        end else if (r_state == S_IDLE) begin
            if (r_count != '0) begin
                r_m_adr <= r_fifo_adr[r_rptr];
                r_m_dat <= r_fifo_dat[r_rptr];
                r_m_sel <= r_fifo_sel[r_rptr];
            end else if (r_rd_pend) begin
                r_m_adr <= r_rd_adr;
                r_m_sel <= r_rd_sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_s_ack <= 1'b0;
            r_s_dat <= '0;
            r_empty <= 1'b1;
        end else begin
            r_s_ack <= w_push | w_rd_done | w_fwd_hit;
            if (w_rd_done) begin
                r_s_dat <= m_dat_i;
            end else if (w_fwd_hit) begin
                r_s_dat <= w_fwd_dat;
            end
            r_empty <= (r_count == '0) && (r_state == S_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: table of single transactions plus
// hand-written overflow, ordering, forwarding and reset sequences.
module tb_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        s_stb_i;
    logic        s_we_i;
    logic [31:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic [3:0]  s_sel_i;
    logic [31:0] s_dat_o;
    logic        s_ack_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_dat_i = '0;
    logic        m_ack_i = 1'b0;
    logic        empty_o;

    always #5 clk = ~clk;

    mem_write_buffer #(.DEPTH_LOG2(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_adr_i (s_adr_i),
        .s_dat_i (s_dat_i),
        .s_sel_i (s_sel_i),
        .s_dat_o (s_dat_o),
        .s_ack_o (s_ack_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_sel_o (m_sel_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i),
        .empty_o (empty_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory-side model: ws wait states, optional stall, byte-lane writes.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];
    int ws = 0;
    bit stall = 1'b0;
    int wcnt = 0;
    int cyc = 0;
    int rd_stb_cyc = -1;
    int wack_cyc = -1;
    int n_rd = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (m_ack_i) begin
            m_ack_i = 1'b0;
        end else if (!m_stb_o) begin
            wcnt = 0;
        end else begin
            if (!m_we_o && rd_stb_cyc < 0) rd_stb_cyc = cyc;
            if (!stall) begin
                if (wcnt >= ws) begin
                    logic [31:0] old;
                    m_ack_i = 1'b1;
                    wcnt = 0;
                    old = mem.exists(m_adr_o) ? mem[m_adr_o] : 32'h0;
                    if (m_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (m_sel_o[b]) old[b*8 +: 8] = m_dat_o[b*8 +: 8];
                        mem[m_adr_o] = old;
                        log_adr.push_back(m_adr_o);
                        log_dat.push_back(m_dat_o);
                        wack_cyc = cyc;
                    end else begin
                        m_dat_i = old;
                        n_rd++;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat);
        s_we_i  = we;
        s_adr_i = a;
        s_dat_i = d;
        s_sel_i = s;
        s_stb_i = 1'b1;
        lat = 0;
        while (lat < 200) begin
            tick();
            lat++;
            if (s_ack_o) break;
        end
        s_stb_i = 1'b0;
    endtask

    task automatic idle_wait();
        int n;
        n = 0;
        repeat (2) tick();
        while (!empty_o && n < 500) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(n < 500), 32'h1);
        tick();
    endtask

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ws;
        logic [31:0] exp_sdat;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        int nl;
        int acks;

        vecs[0] = '{1'b1, 32'h200, 32'h1122_3344, 4'hF, 0, 32'h0,         1};
        vecs[1] = '{1'b0, 32'h200, 32'h0,         4'hF, 0, 32'h1122_3344, 3};
        vecs[2] = '{1'b1, 32'h200, 32'hAABB_CCDD, 4'h2, 1, 32'h1122_3344, 1};
        vecs[3] = '{1'b0, 32'h200, 32'h0,         4'hF, 1, 32'h1122_CC44, 4};
        vecs[4] = '{1'b1, 32'h204, 32'hCAFE_F00D, 4'hC, 3, 32'h1122_CC44, 1};
        vecs[5] = '{1'b0, 32'h204, 32'h0,         4'hF, 3, 32'hCAFE_0000, 6};
        vecs[6] = '{1'b0, 32'h300, 32'h0,         4'hF, 0, 32'h0,         3};
        vecs[7] = '{1'b0, 32'h100, 32'h0,         4'hF, 2, 32'hDEAD_BEEF, 5};

        // Reset held with a live write strobe.
        rst_i   = 1'b0;
        s_stb_i = 1'b1;
        s_we_i  = 1'b1;
        s_adr_i = 32'h999;
        s_dat_i = 32'h5555_5555;
        s_sel_i = 4'hF;
        tick();
        tick();
        chk("rst_s_ack", 32'(s_ack_o), 32'h0);
        chk("rst_m_stb", 32'(m_stb_o), 32'h0);
        chk("rst_m_we", 32'(m_we_o), 32'h0);
        chk("rst_m_adr", m_adr_o, 32'h0);
        chk("rst_m_dat", m_dat_o, 32'h0);
        chk("rst_m_sel", 32'(m_sel_o), 32'h0);
        chk("rst_s_dat", s_dat_o, 32'h0);
        chk("rst_empty", 32'(empty_o), 32'h1);
        s_stb_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_no_push_stb", 32'(m_stb_o), 32'h0);
        chk("rst_no_push_empty", 32'(empty_o), 32'h1);

        // Single write, two wait states.
        ws = 2;
        do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, lat);
        chk("wr1_ack_lat", 32'(lat), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("wr1_stb_c%0d", c), 32'(m_stb_o), 32'h1);
            chk($sformatf("wr1_we_c%0d", c), 32'(m_we_o), 32'h1);
            chk($sformatf("wr1_adr_c%0d", c), m_adr_o, 32'h100);
            chk($sformatf("wr1_dat_c%0d", c), m_dat_o, 32'hDEAD_BEEF);
            chk($sformatf("wr1_sel_c%0d", c), 32'(m_sel_o), 32'hF);
        end
        tick();
        chk("wr1_stb_c5", 32'(m_stb_o), 32'h0);
        chk("wr1_empty_c5", 32'(empty_o), 32'h0);
        tick();
        chk("wr1_empty_c6", 32'(empty_o), 32'h1);
        tick();

        // Table of isolated transactions.
        for (int i = 0; i < 8; i++) begin
            ws = vecs[i].ws;
            do_req(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_sdat", i), s_dat_o, vecs[i].exp_sdat);
            idle_wait();
        end

        // Overflow with a stalled switch.
        ws = 0;
        stall = 1'b1;
        log_adr.delete();
        log_dat.delete();
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'h10 + 32'(4 * i), 32'h5000_0000 + 32'(i), 4'hF, lat);
            chk($sformatf("ovf_lat%0d", i), 32'(lat), (i == 0) ? 32'd1 : 32'd2);
        end
        s_we_i  = 1'b1;
        s_adr_i = 32'h20;
        s_dat_i = 32'h5000_0004;
        s_sel_i = 4'hF;
        s_stb_i = 1'b1;
        acks = 0;
        repeat (4) begin
            tick();
            if (s_ack_o) acks++;
        end
        chk("ovf_full_no_ack", 32'(acks), 32'h0);
        stall = 1'b0;
        lat = 0;
        while (lat < 50) begin
            tick();
            lat++;
            if (s_ack_o) break;
        end
        s_stb_i = 1'b0;
        chk("ovf_5th_lat", 32'(lat), 32'd2);
        idle_wait();
        chk("ovf_nwr", 32'(log_adr.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_adr.size(); i++) begin
            chk($sformatf("ovf_adr%0d", i), log_adr[i], 32'h10 + 32'(4 * i));
            chk($sformatf("ovf_dat%0d", i), log_dat[i], 32'h5000_0000 + 32'(i));
        end

        // Read after write to the same word.
        ws = 1;
        wack_cyc = -1;
        rd_stb_cyc = -1;
        n0 = n_rd;
        do_req(1'b1, 32'h40, 32'h1234_5678, 4'hF, lat);
        chk("raw_wr_lat", 32'(lat), 32'd1);
        do_req(1'b0, 32'h40, 32'h0, 4'hF, lat);
        chk("raw_sdat", s_dat_o, 32'h1234_5678);
        idle_wait();
`ifdef WBUF_RAW_FORWARD_EN
        chk("raw_fwd_no_rd", 32'(n_rd - n0), 32'h0);
`else
        chk("raw_rd_after_wack", 32'(rd_stb_cyc), 32'(wack_cyc + 2));
        chk("raw_nrd", 32'(n_rd - n0), 32'h1);
`endif

        // Two writes to one word, then a read of it.
        ws = 3;
        n0 = n_rd;
        do_req(1'b1, 32'h80, 32'hAAAA_AAAA, 4'hF, lat);
        do_req(1'b1, 32'h80, 32'hBBBB_BBBB, 4'hF, lat);
        do_req(1'b0, 32'h80, 32'h0, 4'hF, lat);
        chk("fwd_sdat", s_dat_o, 32'hBBBB_BBBB);
`ifdef WBUF_RAW_FORWARD_EN
        chk("fwd_lat", 32'(lat), 32'd2);
`endif
        idle_wait();
`ifdef WBUF_RAW_FORWARD_EN
        chk("fwd_nrd", 32'(n_rd - n0), 32'h0);
`else
        chk("fwd_nrd", 32'(n_rd - n0), 32'h1);
`endif

        // Newest match is partial: always the drain path.
        n0 = n_rd;
        do_req(1'b1, 32'h80, 32'hAAAA_AAAA, 4'hF, lat);
        do_req(1'b1, 32'h80, 32'hBBBB_BBBB, 4'h1, lat);
        do_req(1'b0, 32'h80, 32'h0, 4'hF, lat);
        chk("part_sdat", s_dat_o, 32'hAAAA_AABB);
        idle_wait();
        chk("part_nrd", 32'(n_rd - n0), 32'h1);

        // Reset in the middle of a long drain.
        ws = 5;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 32'h400 + 32'(4 * i), 32'h7000_0000 + 32'(i), 4'hF, lat);
        end
        chk("mid_stb_before", 32'(m_stb_o), 32'h1);
        nl = log_adr.size();
        rst_i = 1'b0;
        tick();
        chk("mid_stb_after", 32'(m_stb_o), 32'h0);
        chk("mid_empty", 32'(empty_o), 32'h1);
        chk("mid_s_ack", 32'(s_ack_o), 32'h0);
        rst_i = 1'b1;
        repeat (30) tick();
        chk("mid_no_writes", 32'(log_adr.size()), 32'(nl));
        chk("mid_stb_idle", 32'(m_stb_o), 32'h0);
        chk("mid_empty_end", 32'(empty_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the BIU memory-bus master port and the memory bus switch. Accepts BIU writes into a small FIFO and acknowledges them at once, drains them to memory in order, and services reads only after all older writes have reached memory. The aim is to hide SDRAM/SSRAM write latency from the pipeline's data-memory stalls.

## Interface
- DEPTH_LOG2, 2, log2 of FIFO entries (default 4 entries); legal range 1..4.
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- s_stb_i  in  1  request strobe from the BIU; held until `s_ack_o`.
- s_we_i  in  1  1 = write, 0 = read.
- s_adr_i  in  32  byte address.
- s_dat_i  in  32  write data.
- s_sel_i  in  4  byte lane enables.
- s_dat_o  out  32  read data; valid while `s_ack_o` is high on a read.
- s_ack_o  out  1  one-cycle acknowledge.
- m_stb_o  out  1  strobe to the memory bus switch.
- m_we_o  out  1  write enable.
- m_adr_o  out  32  address.
- m_dat_o  out  32  write data.
- m_sel_o  out  4  byte lanes.
- m_dat_i  in  32  read data from the switch.
- m_ack_i  in  1  acknowledge from the switch.
- empty_o  out  1  high when the FIFO is empty and the drain FSM is IDLE.

## Operation
- Reset (rst_i low at an edge) sets all outputs and state to 0, except `empty_o`, which resets to 1.
- Reset clears the FIFO, read pointer, write pointer and count, and returns the FSM to IDLE.
- Reset mid-drain discards buffered writes; `m_stb_o` is low in the cycle after the reset edge.
- New request: an edge where `s_stb_i`=1 and `s_ack_o`=0 and no read is pending.
  - At an edge where `s_ack_o`=1, `s_stb_i`=1 is the request just acknowledged, not a new one.
- Write with count < 2^DEPTH_LOG2:
  - Push {adr, dat, sel}.
  - Register `s_ack_o`=1 for one cycle.
- Write with the FIFO full: no push and no ack. The request is re-evaluated every edge.
  - A pop at the same edge does not allow the push; the write is accepted at the following edge.
- Push and pop at the same edge: count is unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- Read: latch address and sel, then set `rd_pend`. The read is issued only when the FIFO is empty and the FSM is IDLE.
- Drain FSM states:
  - IDLE → WR when the FIFO is non-empty. A write has priority over a pending read.
    - Register `m_stb_o`=1, `m_we_o`=1, and `m_adr_o`/`m_dat_o`/`m_sel_o` from the FIFO head.
  - IDLE → RD when `rd_pend` is set and the FIFO is empty.
    - Register `m_stb_o`=1, `m_we_o`=0, and the latched address and sel.
  - WR: on `m_ack_i`, pop the head, drop `m_stb_o`, and go to IDLE.
  - RD: on `m_ack_i`, capture `m_dat_i` into `s_dat_o`, register `s_ack_o`=1, clear `rd_pend`, drop `m_stb_o`, and go to IDLE.
- `m_stb_o` is always low for at least one cycle between transfers.
- While `m_stb_o` is high, `m_adr_o`, `m_dat_o`, `m_sel_o` and `m_we_o` are stable.
- `s_dat_o` holds its last read value and is unchanged by writes.

## Timing
- Cycle k is the period after edge k. The request is present in cycle 0 and sampled at edge 1.
- Write accepted: `s_ack_o` is high in cycle 1.
  - Earliest `m_stb_o` is in cycle 2 if the FIFO was empty and the FSM was IDLE.
- Read with the FIFO empty and the FSM IDLE:
  - `m_stb_o` is high in cycle 2.
  - If `m_ack_i` is seen at edge 3, `s_ack_o` and the data are in cycle 3.
  - Total latency = 2 + downstream wait states + 1.
- Read behind N buffered writes: issued only after the last write's `m_ack_i`, plus one IDLE cycle.
- `empty_o` is registered and updates one cycle after the pop or push.
- The switch may hold `m_ack_i` for at most one cycle per strobe. `m_ack_i` with `m_stb_o` low is ignored.

## Configuration
- `WBUF_RAW_FORWARD_EN` defined:
  - A read whose word address (adr[31:2]) matches a FIFO entry is checked against the newest matching entry.
  - If that entry has sel=4'hF, its data is returned in `s_dat_o` with `s_ack_o` in cycle 1. No drain wait and no downstream access.
  - Otherwise (partial sel, or no match) the read uses the normal drain-then-read path.
  - Forwarding works during an active drain. An entry being popped at the same edge is still eligible.
- Not defined:
  - No address comparators.
  - Every read waits for a full drain.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with `s_stb_i`=1 → all outputs 0, `empty_o`=1, and no push.
- Single write 0x0000_0100 / 0xDEAD_BEEF / sel=F, switch acks after 2 wait states:
  - `s_ack_o` in cycle 1.
  - `m_stb_o` in cycles 2–4 with matching address, data and sel.
  - `empty_o`=1 two cycles after the ack.
- Overflow: DEPTH_LOG2=2, switch stalled. Issue 5 writes to 0x10–0x20.
  - The first 4 are acked back-to-back.
  - The 5th waits until the first `m_ack_i`, then is acked one edge later.
  - Memory sees all 5 in order.
- RAW ordering: write 0x40=0x1234_5678, then read 0x40 (macro off).
  - The read strobe appears only after the write's `m_ack_i` plus one idle cycle.
  - `s_dat_o`=0x1234_5678 from the memory model.
- Forwarding (macro on):
  - Writes 0x80=0xAAAA_AAAA (sel F), then 0x80=0xBBBB_BBBB (sel F), then read 0x80 → `s_dat_o`=0xBBBB_BBBB in cycle 1, with no read strobe to the switch.
  - Repeat with the last write sel=4'h1 → normal drain path.
- Reset mid-drain: 3 writes buffered, rst_i=0 while `m_stb_o`=1 → `m_stb_o`=0 in the next cycle, `empty_o`=1, and no further writes reach memory.
